// File: rtl/res_reader_pkg.sv
// res_reader_pkg -- shared constants for the result-RAM readback block.
// Holds the FSM state encodings, the RAM/stream widths, the output FIFO
// depth and the length of each byte-lane read strobe, plus a small
// decode helper used by the strobe logic.
package res_reader_pkg;

  localparam int ADDR_W     = 11;
  localparam int BYTE_W     = 8;
  localparam int DATA_W     = 16;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

  // Number of cycles rd and the bank enable are held low per byte lane.
  localparam int STB_LEN    = 2;
  localparam int STB_CNT_W  = $clog2(STB_LEN + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_LO_STB = 3'd2;
  localparam logic [2:0] S_LO_END = 3'd3;
  localparam logic [2:0] S_HI_STB = 3'd4;
  localparam logic [2:0] S_HI_END = 3'd5;
  localparam logic [2:0] S_DRAIN  = 3'd6;

  // True for the states in which the RAM read strobe is asserted.
  function automatic logic is_strobe(input logic [2:0] st);
    return (st == S_LO_STB) || (st == S_HI_STB);
  endfunction

endpackage

// File: rtl/res_reader_fifo.sv
// res_fifo -- small first-word-fall-through FIFO for assembled result words.
// Ports:
//   CLK        rising-edge clock
//   reset      synchronous, active-low; empties the FIFO
//   push       write push_data this cycle (ignored when full unless popping)
//   push_data  word to store
//   pop        consumer accepts the head word (ignored when empty)
//   head       current head word, forced to 0 while empty
//   empty      no words stored
//   full       FIFO_DEPTH words stored
// Storage is not reset; only pointers and the occupancy count are.
module res_fifo
  import res_reader_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0]     mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic [FIFO_CNT_W-1:0] count;
  logic                  do_push;
  logic                  do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO may still take a
  // push when its head is being consumed.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign empty = (count == '0);
  assign full  = (count == FIFO_CNT_W'(FIFO_DEPTH));
  // Masking keeps the visible output at zero after reset even though the
  // storage itself is left uninitialised.
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/res_reader.sv
// res_reader -- reads a block of 16-bit results out of a dual-bank byte RAM
// and streams them out through a 4-entry FIFO.
// Each word is read in two byte-lane accesses (low bank via oe1, high bank
// via oe2), each with a STB_LEN-cycle active-low rd strobe framed by a
// one-cycle idle gap, giving 7 cycles per word when the FIFO has room.
// Ports:
//   CLK        rising-edge clock
//   reset      synchronous, active-low
//   start      begin a readback (sampled in IDLE only)
//   last_addr  final RAM word address (inclusive), captured on start
//   indata     RAM byte from the currently enabled bank
//   address    RAM word address
//   rd         RAM read strobe, active-low
//   oe1/oe2    low/high byte bank output enables, active-low
//   out_data   result word (FIFO head), out_valid/out_ready handshake
//   busy       readback in progress
//   done       one-cycle pulse when the readback has fully drained
module res_reader
  import res_reader_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [BYTE_W-1:0] indata,
  output logic [ADDR_W-1:0] address,
  output logic              rd,
  output logic              oe1,
  output logic              oe2,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [STB_CNT_W-1:0] stb_cnt;
  logic                 stb_last;
  logic                 addr_last;
  logic [ADDR_W-1:0]    last_q;
  logic [BYTE_W-1:0]    lo_byte;
  logic [BYTE_W-1:0]    hi_byte;
  logic                 fifo_push;
  logic                 fifo_empty;
  logic                 fifo_full;

  assign stb_last  = (stb_cnt == STB_CNT_W'(STB_LEN - 1));
  assign addr_last = (address == last_q);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start)       state_nxt = S_ADDR;
      // Holding here while the FIFO is full keeps rd/oe idle, so no RAM
      // access starts until there is room for its word.
      S_ADDR:   if (!fifo_full)  state_nxt = S_LO_STB;
      S_LO_STB: if (stb_last)    state_nxt = S_LO_END;
      S_LO_END:                  state_nxt = S_HI_STB;
      S_HI_STB: if (stb_last)    state_nxt = S_HI_END;
      S_HI_END:                  state_nxt = addr_last ? S_DRAIN : S_ADDR;
      S_DRAIN:  if (fifo_empty)  state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // Control: state, strobe timing and address. Strobes are registered
  // decodes of the next state so the RAM sees glitch-free edges.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state   <= S_IDLE;
      stb_cnt <= '0;
      address <= '0;
      rd      <= 1'b1;
      oe1     <= 1'b1;
      oe2     <= 1'b1;
    end else begin
      state <= state_nxt;
      rd    <= !is_strobe(state_nxt);
      oe1   <= (state_nxt != S_LO_STB);
      oe2   <= (state_nxt != S_HI_STB);

      if (is_strobe(state) && !stb_last) stb_cnt <= stb_cnt + STB_CNT_W'(1);
      else                               stb_cnt <= '0;

      // Comparing before incrementing means last_addr=2047 stops at 2047
      // instead of wrapping to 0.
      if (state == S_IDLE && start)              address <= '0;
      else if (state == S_HI_END && !addr_last)  address <= address + ADDR_W'(1);
    end
  end

  // Data capture: bytes are taken at the edge ending the last strobe cycle.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && start)         last_q  <= last_addr;
    if (state == S_LO_STB && stb_last)    lo_byte <= indata;
    if (state == S_HI_STB && stb_last)    hi_byte <= indata;
  end

  assign fifo_push = (state == S_HI_END);

  res_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({hi_byte, lo_byte}),
    .pop       (out_ready),
    .head      (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DRAIN) && fifo_empty;

endmodule

// File: doc/res_reader.md
RES_READER -- requirements
Module: res_reader

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-003 SHALL have port start, input, 1, begin readback (sampled in IDLE only).
REQ-004 SHALL have port last_addr, input, 11, final RAM address to read (inclusive), captured on start.
REQ-005 SHALL have port indata, input, 8, RAM data bus (byte from the enabled bank).
REQ-006 SHALL have port address, output, 11, RAM word address.
REQ-007 SHALL have port rd, output, 1, RAM read strobe, active-low.
REQ-008 SHALL have port oe1, output, 1, low-byte bank output enable, active-low.
REQ-009 SHALL have port oe2, output, 1, high-byte bank output enable, active-low.
REQ-010 SHALL have ports out_data (output, 16), out_valid (output, 1) and out_ready (input, 1), forming the result stream; a word transfers on a cycle with out_valid=1 and out_ready=1.
REQ-011 SHALL have port busy, output, 1, high from the cycle after start acceptance until DONE exits.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at end of readback.

Function
REQ-013 SHALL implement states IDLE, ADDR, LO_STB, LO_END, HI_STB, HI_END, DRAIN.
REQ-014 IDLE: start=1 -> latch last_addr, address<=0, go ADDR; otherwise stay.
REQ-015 ADDR (1 cycle): rd=1, oe1=1, oe2=1, address stable; go LO_STB only if FIFO not full, else stay in ADDR.
REQ-016 LO_STB (exactly 2 cycles): rd=0, oe1=0; indata captured into low byte at the rising edge ending the 2nd cycle.
REQ-017 LO_END (1 cycle): rd=1, oe1=1; go HI_STB.
REQ-018 HI_STB (exactly 2 cycles): rd=0, oe2=0; indata captured into high byte at the edge ending the 2nd cycle.
REQ-019 HI_END (1 cycle): rd=1, oe2=1; push {high,low} into FIFO; if address==latched last_addr go DRAIN, else address<=address+1 and go ADDR.
REQ-020 oe1 and oe2 SHALL never be low in the same cycle; rd SHALL be high in every cycle where both are high.
REQ-021 Per-word RAM access SHALL take 7 cycles (ADDR through HI_END) when FIFO not full.
REQ-022 DRAIN: wait until FIFO empty, then assert done for 1 cycle and go IDLE.
REQ-023 FIFO: 4 entries x 16 bits, first-word-fall-through; out_data = head entry, out_valid = not empty.
REQ-024 Simultaneous push and pop SHALL be accepted in the same cycle, count unchanged.
REQ-025 last_addr=0 SHALL read exactly one word; last_addr=2047 SHALL read 2048 words with no address wrap to 0.
REQ-026 start while busy SHALL be ignored; last_addr changes after capture SHALL have no effect.
REQ-027 out_data SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-028 reset=0 at a rising edge SHALL force state IDLE, address=0, rd=1, oe1=1, oe2=1, out_data=0, out_valid=0, busy=0, done=0, FIFO empty.
REQ-029 Reset mid-access SHALL deassert rd/oe1/oe2 at that edge and discard any partial word and FIFO contents.

Structure
REQ-030 State encodings, FIFO depth (4) and strobe length (2) SHALL be constants in the shared package.
REQ-031 The FIFO SHALL be a separate sub-module named res_fifo.

Verification
REQ-032 RAM model bank1[0..3]=0x11,0x22,0x33,0x44, bank2=0xA1..0xA4, last_addr=3, out_ready=1 -> out words 0xA111,0xA222,0xA333,0xA444 in order, then done pulse once.
REQ-033 Same as REQ-032 but out_ready=0 -> after 4 words FSM holds in ADDR with address=3... no: holds at ADDR only after FIFO full; with 4 words FIFO full at DRAIN, no further strobes, done absent until out_ready=1 drains 4 words.
REQ-034 last_addr=0, bank1[0]=0x5A, bank2[0]=0xC3 -> single word 0xC35A, 7 cycles of strobing, done.
REQ-035 last_addr=2047, incrementing pattern, random out_ready -> 2048 words, address never wraps, no lost/duplicated word.
REQ-036 reset=0 during 1st LO_STB cycle of word 2 -> next cycle rd=oe1=oe2=1, out_valid=0, state IDLE.
REQ-037 Every cycle assertion: not(oe1=0 and oe2=0); start pulse while busy -> no restart, address sequence unchanged.
